keccak_hash_collector: RTL and testbench
========================================

# keccak_hash_collector

- Downstream stage of `keccak_top`: consumes the core's 64-bit output word stream (`dst_write`/`dout`) and assembles the HS-bit digest.
- Optionally compares the digest against a share/block target as an unsigned integer.
- Holds the result, with backpressure via `dst_ready`, until the host or mining controller acknowledges it.
- Replaces the ad-hoc shift register in the bus wrapper so that the digest is captured, and hit-checked, without CPU involvement.

## Interface
Parameters:
- `HS`, default 256: digest size in bits; only 256 and 512 are legal. Word count `W = HS/64`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `clear` in 1: synchronous soft clear, same effect as `reset`.
- `dst_write` in 1: core presents a valid `dout` word this cycle.
- `dout` in 64: output word from the core.
- `dst_ready` out 1: stall, active-high. 0 means words are accepted; 1 means the collector is full.
- `target` in HS: compare threshold, sampled in CMP.
- `hash` out HS: assembled digest.
- `hash_valid` out 1: digest complete and held.
- `hash_hit` out 1: `hash <= target`, meaningful while `hash_valid` is 1.
- `hash_ack` in 1: consume the held result.
- `overrun` out 1: sticky; a word arrived while `dst_ready` was 1.

## Operation
States: COLLECT, CMP, HOLD. A word counter `cnt` spans 0..W-1.

**COLLECT** (`dst_ready`=0)
- On each `dst_write`, the byte-reversed word shifts in: `hash <= {rev(dout), hash[HS-1:64]}`.
- `rev(dout)` = `{dout[7:0], dout[15:8], …, dout[63:56]}`.
- After W words, word k (first = 0) sits in `hash[64k+63:64k]`.
- `cnt` increments per word.
- On the word with `cnt==W-1`: `cnt` goes to 0 and the state goes to CMP (HOLD when compare is compiled out).

**CMP** (`dst_ready`=1)
- Register `hash_hit <= (hash <= target)`, full-width unsigned.
- Set `hash_valid`; next state HOLD.

**HOLD** (`dst_ready`=1, `hash_valid`=1)
- `hash`, `hash_hit` and `hash_valid` are stable.
- `hash_ack` leads to COLLECT; `hash_valid` and `hash_hit` go to 0 at the same edge.
- `hash` retains its value until it is overwritten by the next words.

**Boundary and error handling**
- `dst_write` while `dst_ready`=1 (CMP or HOLD): the word is dropped, `hash`/`cnt` are unchanged, and `overrun` is set.
- `overrun` clears only on `reset`/`clear`.
- `hash_ack` in COLLECT or CMP is ignored.
- `dst_write` and `hash_ack` in the same HOLD cycle: the ack is taken and the word is dropped with `overrun`.
- `reset`/`clear` mid-digest: the partial digest is abandoned, and `cnt`, state and all outputs return to reset values. `clear` has priority over `dst_write` and `hash_ack`.

**Reset values:** state COLLECT, `cnt` 0, `hash` 0, `dst_ready` 0, `hash_valid` 0, `hash_hit` 0, `overrun` 0.

## Timing
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Edge e0 captures the last word. With compare enabled:
  - `dst_ready`=1 from e0.
  - `hash_valid`/`hash_hit` from e1, i.e. 1 cycle of compare latency.
- With compare disabled, `dst_ready` and `hash_valid` both rise at e0.
- The core may issue back-to-back words every cycle in COLLECT.
- Any `dst_write` in the cycle after e0 is an overrun; the core must honour `dst_ready` with its own one-cycle pipeline.
- `hash_ack` at edge eA: `dst_ready`=0 from eA, and the first new word is accepted in the cycle after eA.
- Minimum turnaround from last word to next accepted word: 3 cycles with compare, 2 without.

## Configuration
- Macro `KECCAK_COLLECTOR_TARGET_CMP_EN`.
- **Defined:**
  - CMP state and the HS-bit comparator are present.
  - `hash_hit` behaves as specified.
- **Undefined:**
  - CMP is removed; COLLECT goes directly to HOLD.
  - `hash_hit` is tied to 0.
  - The `target` port stays present but is ignored.

## Test plan
- **Byte reversal (HS=256):** words 0x0011223344556677, 0x8899AABBCCDDEEFF, 0, 0 -> `hash[63:0]`=0x7766554433221100, `hash[127:64]`=0xFFEEDDCCBBAA9988, `hash_valid`=1 one cycle after `dst_ready` rises.
- **Compare:** the same digest with `target`=all-ones -> `hit`=1; `target`=0 -> `hit`=0; `target`=exact digest -> `hit`=1 (equality counts).
- **Backpressure:** a 5th word one cycle after the 4th -> word dropped, `hash` unchanged, `overrun`=1 and still 1 after `hash_ack`.
- **Ack/turnaround:** `hash_ack` in HOLD, then 4 back-to-back words starting the cycle after the ack -> second digest correct, `hash_valid` 0 between the two digests.
- **Mid-digest clear:** `clear` after 2 words, then 4 fresh words -> digest built only from the fresh words, `cnt` restarted at 0.
- **HS=512:** 8 words of value k (k=0..7) -> `hash[64k+63:64k]`=rev(k), e.g. `hash[511:448]`=0x0700000000000000; macro undefined -> `hash_hit` stays 0 and `hash_valid` rises with `dst_ready`.

Source files
------------

// File: rtl/keccak_hash_collector.sv
// -----------------------------------------------------------------------------
// keccak_hash_collector
//
// Collects the 64-bit output word stream of keccak_top into an HS-bit digest.
// Each word is byte-reversed and shifted in from the top, so that word k of the
// digest ends up in hash[64k+63:64k]. The completed digest is optionally
// compared against a target, then held until it is acknowledged. While the
// digest is being compared or held, the core is stalled with dst_ready.
//
// Build option:
//   KECCAK_COLLECTOR_TARGET_CMP_EN  defined   -> CMP state and an HS-bit
//                                                unsigned comparator;
//                                                hash_hit = (hash <= target).
//                                   undefined -> COLLECT goes directly to HOLD,
//                                                hash_hit is tied to 0 and
//                                                target is ignored.
//
// Parameters:
//   HS          digest width in bits; only 256 and 512 are legal.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   clear       synchronous soft clear; same effect as reset
//   dst_write   core presents a valid dout word this cycle
//   dout        64-bit output word from the core
//   dst_ready   stall (1 = full, incoming words are dropped)
//   target      compare threshold, sampled in CMP
//   hash        assembled digest
//   hash_valid  digest complete and held
//   hash_hit    hash <= target, meaningful while hash_valid is 1
//   hash_ack    consume the held result
//   overrun     sticky: a word arrived while dst_ready was 1
// -----------------------------------------------------------------------------
module keccak_hash_collector #(
  parameter int HS = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          dst_write,
  input  logic [63:0]   dout,
  output logic          dst_ready,
  input  logic [HS-1:0] target,
  output logic [HS-1:0] hash,
  output logic          hash_valid,
  output logic          hash_hit,
  input  logic          hash_ack,
  output logic          overrun
);

  localparam int W  = HS / 64;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CMP     = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e          state_q,   state_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [HS-1:0]   hash_q,    hash_d;
  logic            overrun_q, overrun_d;

  // The core emits its lanes little-endian; the digest is byte-ordered.
  function automatic logic [63:0] rev_bytes(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

  // NOTE: every variable assigned in this block gets its hold value first, so
  // no path through the case statement leaves one unassigned and no latch is
  // inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hash_d    = hash_q;
    overrun_d = overrun_q;

    unique case (state_q)
      S_COLLECT: begin
        if (dst_write) begin
          hash_d = {rev_bytes(dout), hash_q[HS-1:64]};
          if (cnt_q == CW'(W - 1)) begin
            cnt_d = '0;
`ifdef KECCAK_COLLECTOR_TARGET_CMP_EN
            state_d = S_CMP;
`else
            state_d = S_HOLD;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef KECCAK_COLLECTOR_TARGET_CMP_EN
      S_CMP: begin
        state_d = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (hash_ack) begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    // A word offered while stalled is dropped; only the sticky flag records it.
    if (dst_write && (state_q != S_COLLECT)) begin
      overrun_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others. The digest register is reset too, since
  // hash is a visible output with a defined reset value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= S_COLLECT;
      cnt_q     <= '0;
      hash_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hash_q    <= hash_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef KECCAK_COLLECTOR_TARGET_CMP_EN
  logic hit_q, hit_d;

  // The hit flag is computed once in CMP and then frozen for the HOLD period,
  // so target may change freely while the result is held.
  always_comb begin
    hit_d = hit_q;
    if (state_q == S_CMP) begin
      hit_d = (hash_q <= target);
    end else if ((state_q == S_HOLD) && hash_ack) begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hash_hit = hit_q;
`else
  logic unused_target;
  assign unused_target = ^target;
  assign hash_hit      = 1'b0;
`endif

  assign dst_ready  = (state_q != S_COLLECT);
  assign hash_valid = (state_q == S_HOLD);
  assign hash       = hash_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_keccak_hash_collector.sv
// -----------------------------------------------------------------------------
// tb_keccak_hash_collector
//
// Directed-vector bench for keccak_hash_collector. Two instances: u0 (HS=256)
// carries the main sequence, u1 (HS=512) the wide-digest case. Expected digests
// are pushed into per-instance queues when stimulus is issued; a monitor per
// instance pops and compares whenever hash_valid rises. Works in both builds of
// KECCAK_COLLECTOR_TARGET_CMP_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_keccak_hash_collector;

`ifdef KECCAK_COLLECTOR_TARGET_CMP_EN
  localparam logic CMP_EN = 1'b1;
  localparam int   LAT    = 1;
`else
  localparam logic CMP_EN = 1'b0;
  localparam int   LAT    = 0;
`endif

  localparam logic [255:0] D1 = {64'h0, 64'h0,
                                 64'hFFEEDDCCBBAA9988, 64'h7766554433221100};
  localparam logic [255:0] D2 = {64'hEFCDAB8967452301, 64'h0DF0FECAEFBEADDE,
                                 64'h2010F0E0D0C0B0A0, 64'h0807060504030201};

  logic [63:0] w1 [4];
  logic [63:0] w2 [4];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, clear;
  logic         dst_write0, hash_ack0, dst_ready0, hash_valid0, hash_hit0, overrun0;
  logic [63:0]  dout0;
  logic [255:0] target0, hash0;
  logic         dst_write1, hash_ack1, dst_ready1, hash_valid1, hash_hit1, overrun1;
  logic [63:0]  dout1;
  logic [511:0] target1, hash1, d3;

  keccak_hash_collector #(.HS(256)) u0 (
    .clk(clk), .reset(reset), .clear(clear),
    .dst_write(dst_write0), .dout(dout0), .dst_ready(dst_ready0),
    .target(target0), .hash(hash0), .hash_valid(hash_valid0),
    .hash_hit(hash_hit0), .hash_ack(hash_ack0), .overrun(overrun0)
  );

  keccak_hash_collector #(.HS(512)) u1 (
    .clk(clk), .reset(reset), .clear(clear),
    .dst_write(dst_write1), .dout(dout1), .dst_ready(dst_ready1),
    .target(target1), .hash(hash1), .hash_valid(hash_valid1),
    .hash_hit(hash_hit1), .hash_ack(hash_ack1), .overrun(overrun1)
  );

  typedef struct {
    logic [511:0] h;
    logic         hit;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitors
  logic pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
  int   rc0 = 0, rc1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (dst_ready0 === 1'b1 && !pr0) rc0 = cyc;
    if (hash_valid0 === 1'b1 && !pv0) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb0_unexpected: digest %0h with nothing expected", hash0);
      end else begin
        e = q0.pop_front();
        check("sb0_hash",    hash0,     e.h);
        check("sb0_hit",     hash_hit0, e.hit);
        check("sb0_latency", cyc - rc0, LAT);
      end
    end
    pv0 = (hash_valid0 === 1'b1);
    pr0 = (dst_ready0 === 1'b1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (dst_ready1 === 1'b1 && !pr1) rc1 = cyc;
    if (hash_valid1 === 1'b1 && !pv1) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb1_unexpected: digest %0h with nothing expected", hash1);
      end else begin
        e = q1.pop_front();
        check("sb1_hash",    hash1,     e.h);
        check("sb1_hit",     hash_hit1, e.hit);
        check("sb1_latency", cyc - rc1, LAT);
      end
    end
    pv1 = (hash_valid1 === 1'b1);
    pr1 = (dst_ready1 === 1'b1);
  end

  // ------------------------------------------------------------ stim tasks
  task automatic word0(input logic [63:0] w);
    dst_write0 = 1'b1;
    dout0      = w;
    @(posedge clk); #1;
    dst_write0 = 1'b0;
  endtask

  task automatic word1(input logic [63:0] w);
    dst_write1 = 1'b1;
    dout1      = w;
    @(posedge clk); #1;
    dst_write1 = 1'b0;
  endtask

  task automatic ack0();
    hash_ack0 = 1'b1;
    @(posedge clk); #1;
    hash_ack0 = 1'b0;
  endtask

  task automatic ack1();
    hash_ack1 = 1'b1;
    @(posedge clk); #1;
    hash_ack1 = 1'b0;
  endtask

  task automatic wait_valid0(input string name);
    int n = 0;
    while (hash_valid0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hash_valid0 !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: hash_valid timeout after %0d cycles", name, n);
    end
  endtask

  task automatic wait_valid1(input string name);
    int n = 0;
    while (hash_valid1 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (hash_valid1 !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: hash_valid timeout after %0d cycles", name, n);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    w1 = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0, 64'h0};
    w2 = '{64'h0102030405060708, 64'hA0B0C0D0E0F01020,
           64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF};
    for (int k = 0; k < 8; k++) d3[64*k +: 64] = {8'(k), 56'h0};

    reset = 1'b1; clear = 1'b0;
    dst_write0 = 1'b0; dout0 = '0; hash_ack0 = 1'b0; target0 = '0;
    dst_write1 = 1'b0; dout1 = '0; hash_ack1 = 1'b0; target1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_hash",       hash0,       '0);
    check("rst_dst_ready",  dst_ready0,  1'b0);
    check("rst_hash_valid", hash_valid0, 1'b0);
    check("rst_hash_hit",   hash_hit0,   1'b0);
    check("rst_overrun",    overrun0,    1'b0);

    // Byte reversal, target all-ones -> hit
    target0 = '1;
    q0.push_back(exp_t'{h: 512'(D1), hit: CMP_EN});
    for (int i = 0; i < 4; i++) word0(w1[i]);
    check("ready_after_last", dst_ready0, 1'b1);
    wait_valid0("t1");
    check("rev_word0", hash0[63:0],   64'h7766554433221100);
    check("rev_word1", hash0[127:64], 64'hFFEEDDCCBBAA9988);
    ack0();
    check("ack_valid_low", hash_valid0, 1'b0);
    check("ack_hit_low",   hash_hit0,   1'b0);
    check("ack_ready_low", dst_ready0,  1'b0);
    check("ack_hash_kept", hash0,       D1);

    // target zero -> no hit
    target0 = '0;
    q0.push_back(exp_t'{h: 512'(D1), hit: 1'b0});
    for (int i = 0; i < 4; i++) word0(w1[i]);
    wait_valid0("t2");
    ack0();

    // target equal to digest -> hit; fifth word right after the fourth is dropped
    target0 = D1;
    q0.push_back(exp_t'{h: 512'(D1), hit: CMP_EN});
    for (int i = 0; i < 4; i++) word0(w1[i]);
    word0(64'hBADBADBADBADBAD0);
    check("bp_overrun",     overrun0, 1'b1);
    check("bp_hash_intact", hash0,    D1);
    wait_valid0("t3");
    ack0();
    check("overrun_sticky", overrun0,    1'b1);
    check("gap_valid_low",  hash_valid0, 1'b0);

    // Back-to-back words the cycle after the ack; digest above target -> no hit
    q0.push_back(exp_t'{h: 512'(D2), hit: 1'b0});
    for (int i = 0; i < 4; i++) word0(w2[i]);
    wait_valid0("t4");
    ack0();

    // Mid-digest clear; ack in COLLECT ignored; clear beats a concurrent word
    target0 = '1;
    word0(w2[0]);
    word0(w2[1]);
    ack0();
    check("collect_ack_ignored", dst_ready0, 1'b0);
    clear = 1'b1; dst_write0 = 1'b1; dout0 = w2[2];
    @(posedge clk); #1;
    clear = 1'b0; dst_write0 = 1'b0;
    check("clr_hash",    hash0,    '0);
    check("clr_overrun", overrun0, 1'b0);
    check("clr_ready",   dst_ready0, 1'b0);
    q0.push_back(exp_t'{h: 512'(D1), hit: CMP_EN});
    for (int i = 0; i < 4; i++) word0(w1[i]);
    wait_valid0("t5");

    // Ack and word in the same HOLD cycle: ack taken, word dropped
    hash_ack0 = 1'b1; dst_write0 = 1'b1; dout0 = 64'hFEEDFACEFEEDFACE;
    @(posedge clk); #1;
    hash_ack0 = 1'b0; dst_write0 = 1'b0;
    check("ackw_valid_low", hash_valid0, 1'b0);
    check("ackw_overrun",   overrun0,    1'b1);
    check("ackw_hash_kept", hash0,       D1);

    // HS=512: word k carries value k
    target1 = '1;
    q1.push_back(exp_t'{h: d3, hit: CMP_EN});
    for (int k = 0; k < 8; k++) word1(64'(k));
    wait_valid1("t6");
    check("w512_top", hash1[511:448], 64'h0700000000000000);
    ack1();
    check("w512_overrun", overrun1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
